tape_loader: RTL and testbench
==============================

Name: tape_loader

Overview:
- Upstream stage of the tape interface / UTM core pair.
- Clears the tape RAM to blank, then accepts the initial tape contents as a valid/ready symbol stream and writes them into the RAM through its write port.
- Holds the core in reset for the whole of this sequence and releases it once the tape is loaded.
- Supports a reload request that re-runs the full clear/load/release sequence.

Parameters:
- SYM_WIDTH, 3, bits per tape symbol (matches core sym_in/new_sym)
- ADDR_WIDTH, 5, tape address bits; DEPTH = 2**ADDR_WIDTH cells
- BLANK_SYM, 0, symbol written to every cell during clear
- HOLD_CYCLES, 2, cycles core_reset stays high after the final load write

Ports:
- clock  in  1  single system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- in_sym  in  SYM_WIDTH  incoming tape symbol
- in_valid  in  1  in_sym/in_last valid
- in_last  in  1  marks the final symbol of the tape image
- in_ready  out  1  loader accepts a symbol this cycle
- reload  in  1  single-cycle request to restart the load sequence
- wr_en  out  1  tape RAM write strobe
- wr_addr  out  ADDR_WIDTH  tape RAM write address
- wr_data  out  SYM_WIDTH  tape RAM write data
- core_reset  out  1  drives the reset of the core and tape interface
- load_done  out  1  tape loaded and core running
- overflow  out  1  image exceeded DEPTH and was truncated (sticky)

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, core_reset=1, load_done=0, overflow=0; state=CLEAR, ptr=0, hold_cnt=0.
  - in_ready is a combinational decode: in_ready = (state==LOAD).
- Reset asserted mid-operation, in any state, returns the block to the values above on the next edge. Partial RAM contents are overwritten by the following CLEAR.
- States: CLEAR -> LOAD -> HOLD -> RUN; reload in RUN -> CLEAR.
- CLEAR:
  - One write per cycle: wr_en=1, wr_addr=ptr, wr_data=BLANK_SYM; ptr++.
  - After the write to DEPTH-1: ptr wraps to 0 and state goes to LOAD.
  - Takes exactly DEPTH cycles. in_ready=0 throughout.
- LOAD:
  - A symbol is accepted on any edge with in_valid & in_ready.
  - Write latency is 1 cycle: accept at edge N gives wr_en=1, wr_addr=ptr, wr_data=in_sym registered at edge N, visible in cycle N+1; ptr++.
  - wr_en=0 on cycles with no accept.
  - Accept with in_last=1: go to HOLD.
  - Accept at ptr=DEPTH-1 with in_last=0: set overflow=1 and go to HOLD. The write to DEPTH-1 still occurs; later symbols are not accepted (in_ready=0).
  - Accept at ptr=DEPTH-1 with in_last=1: no overflow.
- HOLD:
  - hold_cnt counts up from 0. core_reset=1 and wr_en=0 after the final write cycle.
  - After HOLD_CYCLES cycles in HOLD: go to RUN.
- RUN:
  - core_reset=0 and load_done=1, both registered and changing on the same edge.
  - in_valid is ignored.
  - reload=1 gives CLEAR at the next edge: core_reset=1, load_done=0, overflow cleared, ptr=0.
- reload in CLEAR, LOAD or HOLD: ignored.
- reset and reload together: reset wins.
- Cells not written in LOAD keep BLANK_SYM. The core head starts at address 0, which is the first loaded symbol.

Decomposition:
- Shared package utm_pkg holds:
  - SYM_WIDTH, BLANK_SYM (common with the core and tape interface)
  - the loader state encoding: CLEAR, LOAD, HOLD, RUN, 2-bit
- No sub-module: a single module with a counter-based FSM. The hold counter stays inline.

Test Plan:
- Reset 5 cycles then release:
  - exactly 32 consecutive wr_en cycles, addr 0..31, data 0;
  - in_ready rises in cycle 33 after reset release;
  - core_reset=1 throughout.
- Stream 3,1,2 (last on 2) with in_valid held high:
  - writes (0,3),(1,1),(2,2) on consecutive cycles, one cycle after each accept;
  - in_ready low the cycle after the last accept;
  - core_reset falls and load_done rises exactly 2 cycles after the final write cycle.
- Same image with in_valid toggled 1,0,1,0,1:
  - writes only follow valid cycles, addresses stay contiguous 0,1,2;
  - no write on idle cycles.
- Stream 40 symbols, last on 40th:
  - 32 writes (addr 0..31), overflow=1, in_ready=0 after the 32nd accept;
  - symbols 33..40 not accepted;
  - core released after HOLD.
- In RUN pulse reload, plus reload pulsed during LOAD:
  - LOAD-time pulse has no effect;
  - RUN-time pulse: core_reset=1 and load_done=0 next cycle, followed by the full 32-cycle blank clear, overflow=0.
- Assert reset in the middle of LOAD after 2 accepts:
  - next cycle all outputs are at reset values;
  - the sequence restarts with CLEAR from address 0.

Source files
------------

// File: rtl/utm_pkg.sv
// Shared definitions for the UTM core, tape interface and tape loader.
// Holds the tape symbol format and the loader state encoding.
package utm_pkg;

    localparam int unsigned SYM_WIDTH = 3;

    typedef logic [SYM_WIDTH-1:0] sym_t;

    // Symbol written to every tape cell while clearing.
    localparam sym_t BLANK_SYM = sym_t'(0);

    // Loader sequence: clear RAM, load image, hold core in reset, run.
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        HOLD  = 2'd2,
        RUN   = 2'd3
    } loader_state_e;

endpackage : utm_pkg

// File: rtl/tape_loader_if.sv
// Tape loader bus: symbol stream in, tape RAM write port and core control out.
//   in_sym/in_valid/in_last/in_ready : valid/ready tape image stream
//   reload                           : request to restart the load sequence
//   wr_en/wr_addr/wr_data            : tape RAM write port
//   core_reset/load_done/overflow    : core control and status
// slave modport is the loader, master modport is the image source / system side.
interface tape_loader_if #(
    parameter int unsigned ADDR_WIDTH = 5
) ();

    logic [utm_pkg::SYM_WIDTH-1:0] in_sym;
    logic                          in_valid;
    logic                          in_last;
    logic                          in_ready;
    logic                          reload;
    logic                          wr_en;
    logic [ADDR_WIDTH-1:0]         wr_addr;
    logic [utm_pkg::SYM_WIDTH-1:0] wr_data;
    logic                          core_reset;
    logic                          load_done;
    logic                          overflow;

    modport slave (
        input  in_sym, in_valid, in_last, reload,
        output in_ready, wr_en, wr_addr, wr_data, core_reset, load_done, overflow
    );

    modport master (
        output in_sym, in_valid, in_last, reload,
        input  in_ready, wr_en, wr_addr, wr_data, core_reset, load_done, overflow
    );

endinterface : tape_loader_if

// File: rtl/tape_loader.sv
// Tape loader: blanks the tape RAM, writes the incoming tape image from
// address 0 upward, holds the core in reset until HOLD_CYCLES after the final
// write, then releases it. A reload while running repeats the whole sequence.
// Ports:
//   clock : system clock, posedge
//   reset : synchronous, active-high
//   bus   : tape_loader_if.slave (stream in, RAM write port, core control out)
module tape_loader
    import utm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic          clock,
    input  logic          reset,
    tape_loader_if.slave  bus
);

    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    localparam addr_t LAST_ADDR = addr_t'(DEPTH - 1);

    loader_state_e     state_q, state_d;
    addr_t             ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              wr_en_q, wr_en_d;
    addr_t             wr_addr_q, wr_addr_d;
    sym_t              wr_data_q, wr_data_d;
    logic              core_reset_q, core_reset_d;
    logic              load_done_q, load_done_d;
    logic              overflow_q, overflow_d;

    logic accept_c;
    logic ptr_last_c;
    logic hold_done_c;

    assign accept_c    = (state_q == LOAD) && bus.in_valid;
    assign ptr_last_c  = (ptr_q == LAST_ADDR);
    // Last cycle of HOLD; a HOLD_CYCLES of 0 still spends one cycle in HOLD.
    assign hold_done_c = ((32'(hold_cnt_q) + 32'd1) >= HOLD_CYCLES);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLEAR: if (ptr_last_c) state_d = LOAD;
            LOAD:  if (accept_c && (bus.in_last || ptr_last_c)) state_d = HOLD;
            HOLD:  if (hold_done_c) state_d = RUN;
            RUN:   if (bus.reload) state_d = CLEAR;
            default: state_d = CLEAR;
        endcase
    end

    // Output and datapath next values; every output is registered below.
    always_comb begin
        ptr_d        = ptr_q;
        hold_cnt_d   = hold_cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        core_reset_d = core_reset_q;
        load_done_d  = load_done_q;
        overflow_d   = overflow_q;

        unique case (state_q)
            CLEAR: begin
                // ptr wraps to 0 naturally after the write to DEPTH-1.
                wr_en_d      = 1'b1;
                wr_addr_d    = ptr_q;
                wr_data_d    = BLANK_SYM;
                ptr_d        = ptr_q + addr_t'(1);
                hold_cnt_d   = '0;
                core_reset_d = 1'b1;
                load_done_d  = 1'b0;
            end
            LOAD: begin
                if (accept_c) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = bus.in_sym;
                    ptr_d     = ptr_q + addr_t'(1);
                    if (bus.in_last || ptr_last_c) begin
                        ptr_d = '0;
                    end
                    // Image longer than the tape: last cell written, rest dropped.
                    if (ptr_last_c && !bus.in_last) begin
                        overflow_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (hold_done_c) begin
                    hold_cnt_d   = '0;
                    core_reset_d = 1'b0;
                    load_done_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            RUN: begin
                if (bus.reload) begin
                    ptr_d        = '0;
                    core_reset_d = 1'b1;
                    load_done_d  = 1'b0;
                    overflow_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q        <= '0;
            hold_cnt_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            core_reset_q <= core_reset_d;
            load_done_q  <= load_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.in_ready   = (state_q == LOAD);
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.core_reset = core_reset_q;
    assign bus.load_done  = load_done_q;
    assign bus.overflow   = overflow_q;

endmodule : tape_loader

// File: tb/tb_tape_loader.sv
// Testbench for tape_loader: random tape images and valid patterns checked
// against a tape-level reference (expected RAM image and release timing).
module tb_tape_loader;

    localparam int unsigned DEPTH = 32;

    logic clk;
    logic rst;

    int n_checks;
    int n_pass;

    int img [64];
    int ram [DEPTH];

    tape_loader_if #(.ADDR_WIDTH(5)) bus ();

    tape_loader #(
        .ADDR_WIDTH  (5),
        .HOLD_CYCLES (2)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock; outputs are then stable until the next posedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called in the first cycle of CLEAR (after reset release or reload edge).
    task automatic check_clear(input bit from_reset);
        chk("entry_wr_en", bus.wr_en, 0);
        chk("entry_core_reset", bus.core_reset, 1);
        chk("entry_load_done", bus.load_done, 0);
        chk("entry_overflow", bus.overflow, 0);
        chk("entry_in_ready", bus.in_ready, 0);
        if (from_reset) begin
            chk("reset_wr_addr", bus.wr_addr, 0);
            chk("reset_wr_data", bus.wr_data, 0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            chk("clear_wr_en", bus.wr_en, 1);
            chk("clear_addr", bus.wr_addr, i);
            chk("clear_data", bus.wr_data, 0);
            chk("clear_core_reset", bus.core_reset, 1);
            chk("clear_in_ready", bus.in_ready, (i == DEPTH - 1) ? 1 : 0);
            if (bus.wr_en) ram[bus.wr_addr] = int'(bus.wr_data);
        end
    endtask

    // Stream img[0..n-1] starting in the first LOAD cycle.
    // mode 0: valid always, 1: valid toggles 1,0,1,..., 2: random valid.
    task automatic run_load(input int n, input int mode, input bit pulse_reload);
        int  k = 0;
        bit  done = 0;
        bit  ovf = 0;
        int  c = -1;
        bit  finished = 0;
        bit  v;
        bit  lst;
        int  sym;
        bit  pv;
        int  pa;
        int  pd;
        bit  exp_ld;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (k < n) begin
                sym = img[k];
                lst = (k == n - 1);
            end else begin
                sym = int'($urandom_range(0, 7));
                lst = 1'($urandom_range(0, 1));
            end
            bus.in_valid = v;
            bus.in_sym   = 3'(sym);
            bus.in_last  = lst;
            bus.reload   = pulse_reload && (cyc == 1);
            chk("in_ready", bus.in_ready, done ? 0 : 1);
            pv = 1'b0;
            if (v && !done) begin
                pv = 1'b1;
                pa = k;
                pd = sym;
                k++;
                if (lst || k == DEPTH) begin
                    done = 1'b1;
                    ovf  = !lst;
                end
            end
            tick();
            bus.reload = 1'b0;
            chk("load_wr_en", bus.wr_en, pv);
            if (pv) begin
                chk("load_addr", bus.wr_addr, pa);
                chk("load_data", bus.wr_data, pd);
            end
            if (bus.wr_en) ram[bus.wr_addr] = int'(bus.wr_data);
            if (done) c++;
            exp_ld = (c >= 2);
            chk("load_done", bus.load_done, exp_ld);
            chk("core_reset", bus.core_reset, !exp_ld);
            chk("overflow", bus.overflow, done ? ovf : 1'b0);
            if (c == 4) finished = 1'b1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!finished) chk("load_timeout", 0, 1);
    endtask

    // Tape contents after a load: image prefix, blanks elsewhere.
    task automatic check_ram(input int n);
        for (int i = 0; i < DEPTH; i++) begin
            chk("ram_cell", ram[i], (i < n) ? img[i] : 0);
        end
    endtask

    task automatic do_reload();
        bus.reload = 1'b1;
        tick();
        bus.reload = 1'b0;
        check_clear(1'b0);
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        bus.in_sym   = '0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.reload   = 1'b0;
        for (int i = 0; i < DEPTH; i++) ram[i] = -1;

        @(negedge clk);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0;
        check_clear(1'b1);

        // Short image, valid held high.
        img[0] = 3; img[1] = 1; img[2] = 2;
        run_load(3, 0, 1'b0);
        check_ram(3);

        // Same image with gapped valid and an ignored reload during LOAD.
        do_reload();
        run_load(3, 1, 1'b1);
        check_ram(3);

        // Oversized image: truncated at 32 with overflow.
        do_reload();
        for (int i = 0; i < 40; i++) img[i] = int'($urandom_range(0, 7));
        run_load(40, 0, 1'b0);
        check_ram(40);

        // Exactly full image: last on the final cell, no overflow.
        do_reload();
        for (int i = 0; i < 32; i++) img[i] = int'($urandom_range(0, 7));
        run_load(32, 2, 1'b0);
        check_ram(32);

        // Random images and valid patterns.
        for (int t = 0; t < 4; t++) begin
            int n;
            n = int'($urandom_range(1, 40));
            do_reload();
            for (int i = 0; i < n; i++) img[i] = int'($urandom_range(0, 7));
            run_load(n, 2, 1'($urandom_range(0, 1)));
            check_ram(n);
        end

        // Reset in the middle of LOAD after two accepts.
        do_reload();
        bus.in_valid = 1'b1;
        bus.in_sym   = 3'd5;
        bus.in_last  = 1'b0;
        tick();
        chk("mid_wr0_en", bus.wr_en, 1);
        chk("mid_wr0_addr", bus.wr_addr, 0);
        chk("mid_wr0_data", bus.wr_data, 5);
        bus.in_sym = 3'd6;
        tick();
        chk("mid_wr1_addr", bus.wr_addr, 1);
        chk("mid_wr1_data", bus.wr_data, 6);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        check_clear(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_tape_loader
